// File: rtl/multi_pipe_param.sv
// Four-stage pipelined WIDTHxWIDTH multiplier, unsigned or two's-complement per transaction.
// Signed operands are reduced to magnitudes, multiplied, then negated when the operand signs differ.
module multi_pipe_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul_out
);

    localparam int LAT   = 4;
    localparam int NPAIR = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;

    // Valid bits per stage: [0]=S1 operands, [1]=S2 pair sums, [2]=S3 final sum, [3]=S4 output.
    logic [LAT-1:0]   r_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_sgn;
    logic [PW-1:0]    r_s2_sum [NPAIR];
    logic             r_s2_neg;
    logic [PW-1:0]    r_s3_data;
    logic [PW-1:0]    r_s4_data;

    logic             w_advance;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_pair [NPAIR];
    logic [PW-1:0]    w_total;
    logic [PW-1:0]    w_s3_next;

    // The whole pipeline moves as one; it only freezes when a finished result is not taken.
    assign w_advance = !r_vld[LAT-1] || out_ready;
    assign in_ready  = w_advance || rst;
    assign out_valid = r_vld[LAT-1];
    assign mul_out   = r_s4_data;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    assign w_a_neg = r_s1_sgn && r_s1_a[WIDTH-1];
    assign w_b_neg = r_s1_sgn && r_s1_b[WIDTH-1];
    assign w_neg   = w_a_neg ^ w_b_neg;
    assign w_a_mag = w_a_neg ? -r_s1_a : r_s1_a;
    assign w_b_mag = w_b_neg ? -r_s1_b : r_s1_b;
    assign w_a_ext = {{WIDTH{1'b0}}, w_a_mag};

    always_comb begin
        for (int i = 0; i < NPAIR; i++) begin
            w_pair[i] = (w_b_mag[2*i]   ? (w_a_ext << (2*i))     : '0)
                      + (w_b_mag[2*i+1] ? (w_a_ext << (2*i + 1)) : '0);
        end
    end

    // Negating a zero magnitude product yields zero, so no extra zero guard is needed.
    always_comb begin
        w_total = '0;
        for (int i = 0; i < NPAIR; i++) begin
            w_total = w_total + r_s2_sum[i];
        end
        w_s3_next = r_s2_neg ? -w_total : w_total;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_sgn  <= 1'b0;
            r_s2_neg  <= 1'b0;
            r_s3_data <= '0;
            r_s4_data <= '0;
            for (int i = 0; i < NPAIR; i++) begin
                r_s2_sum[i] <= '0;
            end
        end else if (w_advance) begin
            r_vld     <= {r_vld[LAT-2:0], in_valid};
            r_s1_a    <= mul_a;
            r_s1_b    <= mul_b;
            r_s1_sgn  <= mul_signed;
            r_s2_neg  <= w_neg;
            r_s3_data <= w_s3_next;
            r_s4_data <= r_vld[2] ? r_s3_data : '0;
            for (int i = 0; i < NPAIR; i++) begin
                r_s2_sum[i] <= w_pair[i];
            end
        end
    end

endmodule

// File: doc/multi_pipe_param.md
MULTI_PIPE_PARAM -- requirements
Module: multi_pipe_param

Parameters
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal values are even integers 4..32.
REQ-002 SHALL have parameter LAT, fixed at 4 and not overridable: accept-to-result latency in cycles with no stall.

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and mode are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-007 SHALL have port mul_a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port mul_b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port mul_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled per transaction.
REQ-010 SHALL have port out_valid, output, 1 bit: mul_out holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port mul_out, output, 2*WIDTH bits: exact product.

Function
REQ-013 SHALL accept a transaction when in_valid && in_ready at a rising clk edge.
REQ-014 SHALL use four pipeline stages, each carrying a valid bit and its data:
- S1: registered operands and mode.
- S2: pairwise sums of WIDTH partial products, giving WIDTH/2 registered sums.
- S3: registered final sum with sign correction.
- S4: output register.
REQ-015 SHALL advance the whole pipeline together (advance = !out_valid || out_ready); when advance=0, every stage holds its state.
REQ-016 SHALL drive in_ready = advance, combinationally from out_ready and the S4 valid bit.
REQ-017 SHALL, with no stall, assert out_valid exactly 4 cycles after the accepting edge, with mul_out = product of that transaction.
REQ-018 SHALL, when mul_signed=0, produce mul_out = mul_a * mul_b, unsigned and exact in 2*WIDTH bits.
REQ-019 SHALL, when mul_signed=1, produce mul_out = signed(mul_a) * signed(mul_b) as exact 2*WIDTH-bit two's complement, including (-2^(WIDTH-1))^2.
REQ-020 SHALL implement signed mode as magnitude multiply followed by negation when the operand signs differ; a zero product SHALL never yield a nonzero value.
REQ-021 SHALL drive mul_out to 0 whenever out_valid=0.
REQ-022 SHALL hold mul_out and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL issue results in acceptance order, with no drops and no duplicates; throughput SHALL be 1 transaction per cycle when out_ready is held at 1.
REQ-024 SHALL, when S4 is consumed and S3 holds valid data on the same edge, load S4 from S3 with no bubble.
REQ-025 SHALL treat a stage whose valid bit is 0 as a bubble; bubbles SHALL never produce out_valid.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, clear all valid bits and all data registers to 0; out_valid=0 and mul_out=0 on the following cycle.
REQ-027 SHALL discard all in-flight transactions on reset mid-operation; no result from before reset SHALL appear afterwards.
REQ-028 SHALL hold in_ready=1 while rst=1 (pipeline empty), and SHALL NOT accept any transaction on an edge where rst=1.
REQ-029 SHALL accept a transaction on the first edge after rst deasserts.

Verification (WIDTH=8 unless stated)
REQ-030 SHALL cover: unsigned 255*255 with out_ready=1 -> out_valid 4 cycles later, mul_out=16'hFE01, then out_valid=0 and mul_out=0.
REQ-031 SHALL cover: signed -128*-128 -> 16'h4000; signed -1*1 -> 16'hFFFF; signed 0*-5 -> 16'h0000.
REQ-032 SHALL cover: back-to-back unsigned 3*4, 5*6, 7*8 with out_ready=1 -> out_valid on 3 consecutive cycles with 12, 30, 56.
REQ-033 SHALL cover: same three transactions with out_ready=0 for 6 cycles -> first result held at 12, in_ready=0 while stalled, then 12, 30, 56 in order once out_ready=1.
REQ-034 SHALL cover: two accepted transactions, rst pulsed for 1 cycle 2 cycles later -> no out_valid for those transactions; a new 2*3 after reset -> 6 after 4 cycles.
REQ-035 SHALL cover, at WIDTH=16: unsigned 65535*65535 -> 32'hFFFE0001; signed -32768*32767 -> 32'hC0008000.
